// File: rtl/mux4_scan_ctrl_if.sv
// Handshake/bus bundle between the scan controller and its mux + downstream consumer.
// Latency: none (pure wiring bundle).
// Backpressure: carries the valid/ready pair; the consumer holds off a snapshot with ready low.
interface mux4_scan_ctrl_if;
  logic       start;
  logic       mux_out;
  logic       s1;
  logic       s0;
  logic       busy;
  logic [3:0] data;
  logic       valid;
  logic       ready;

  // Controller side: drives the selects and the snapshot.
  modport master (
    input  start,
    input  mux_out,
    input  ready,
    output s1,
    output s0,
    output busy,
    output data,
    output valid
  );

  // Environment side: mux, requester and snapshot consumer.
  modport slave (
    output start,
    output mux_out,
    output ready,
    input  s1,
    input  s0,
    input  busy,
    input  data,
    input  valid
  );
endinterface

// File: rtl/mux4_scan_ctrl.sv
// Walks a 4:1 mux select through channels 0..3, settles, samples mux_out into a 4-bit snapshot.
// Latency: snapshot valid 4*SETTLE_CYCLES clocks after the accepted start edge.
// Backpressure: snapshot and valid held in DONE until ready; start ignored while busy or valid.
// Optional: define MUX4_SCAN_CONTINUOUS_EN to relaunch a scan on every handshake.
module mux4_scan_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  mux4_scan_ctrl_if.master bus
);

  // Settle times below one clock are treated as one clock.
  localparam int              S_EFF    = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(S_EFF - 1);

  // The settle counter must be able to reach SETTLE_CYCLES-1.
  if (CNT_W < 1 || (S_EFF - 1) >= (1 << CNT_W)) begin : g_cnt_w_check
    $error("mux4_scan_ctrl: CNT_W too narrow for SETTLE_CYCLES");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_ch;
  logic [1:0]       r_sel;
  logic [3:0]       r_data;
  logic             r_busy;
  logic             r_valid;

  logic w_settled;
  logic w_last_ch;

  assign w_settled = (r_cnt == CNT_LAST);
  assign w_last_ch = (r_ch == 2'd3);

  // Scan sequencer: every output is a flop, so the selects never glitch between edges.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ch    <= 2'd0;
      r_sel   <= 2'd0;
      r_data  <= 4'b0000;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_sel   <= 2'd0;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          if (bus.start) begin
            // Launch: channel 0 is already selected, so settling starts now.
            r_state <= ST_SCAN;
            r_ch    <= 2'd0;
            r_cnt   <= '0;
            r_data  <= 4'b0000;
            r_busy  <= 1'b1;
          end
        end

        ST_SCAN: begin
          if (w_settled) begin
            // mux_out has been stable for the full settle window on this channel.
            r_data[r_ch] <= bus.mux_out;
            r_cnt        <= '0;
            if (w_last_ch) begin
              r_state <= ST_DONE;
              r_ch    <= 2'd0;
              r_sel   <= 2'd0;
              r_busy  <= 1'b0;
              r_valid <= 1'b1;
            end else begin
              r_ch  <= r_ch + 2'd1;
              r_sel <= r_ch + 2'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          // Snapshot is frozen here; start has no effect until the consumer takes it.
          if (bus.ready) begin
            r_valid <= 1'b0;
`ifdef MUX4_SCAN_CONTINUOUS_EN
            r_state <= ST_SCAN;
            r_ch    <= 2'd0;
            r_sel   <= 2'd0;
            r_cnt   <= '0;
            r_data  <= 4'b0000;
            r_busy  <= 1'b1;
`else
            r_state <= ST_IDLE;
`endif
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_ch    <= 2'd0;
          r_sel   <= 2'd0;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s1    = r_sel[1];
  assign bus.s0    = r_sel[0];
  assign bus.busy  = r_busy;
  assign bus.valid = r_valid;
  assign bus.data  = r_data;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench: two controllers (settle 1 and settle 3) driven by a mux model with random noise
// outside capture edges; a cycle-level reference model feeds a snapshot scoreboard.
module tb_mux4_scan_ctrl;

  localparam int S_A = 1;
  localparam int S_B = 3;

  typedef struct {
    logic [3:0] d;
    int         due;
  } exp_t;

  logic       clk;
  logic       rst_n  [2];
  logic       start  [2];
  logic       ready  [2];
  logic       noise  [2];
  logic [3:0] in_vec [2];

  logic [1:0] sel_o   [2];
  logic       busy_o  [2];
  logic       valid_o [2];
  logic [3:0] data_o  [2];

  int n_run;
  int n_fail;

  // Reference model state: 0 idle, 1 scanning, 2 holding snapshot.
  int   m_mode [2];
  int   m_e    [2];
  int   cyc;
  exp_t q [2][$];

  mux4_scan_ctrl_if bus_a ();
  mux4_scan_ctrl_if bus_b ();

  assign bus_a.start   = start[0];
  assign bus_a.ready   = ready[0];
  assign bus_a.mux_out = in_vec[0][{bus_a.s1, bus_a.s0}] ^ noise[0];
  assign bus_b.start   = start[1];
  assign bus_b.ready   = ready[1];
  assign bus_b.mux_out = in_vec[1][{bus_b.s1, bus_b.s0}] ^ noise[1];

  assign sel_o[0]   = {bus_a.s1, bus_a.s0};
  assign sel_o[1]   = {bus_b.s1, bus_b.s0};
  assign busy_o[0]  = bus_a.busy;
  assign busy_o[1]  = bus_b.busy;
  assign valid_o[0] = bus_a.valid;
  assign valid_o[1] = bus_b.valid;
  assign data_o[0]  = bus_a.data;
  assign data_o[1]  = bus_b.data;

  mux4_scan_ctrl #(.SETTLE_CYCLES(S_A), .CNT_W(4)) dut_a (
    .clock   (clk),
    .reset_n (rst_n[0]),
    .bus     (bus_a)
  );

  mux4_scan_ctrl #(.SETTLE_CYCLES(S_B), .CNT_W(4)) dut_b (
    .clock   (clk),
    .reset_n (rst_n[1]),
    .bus     (bus_b)
  );

  function automatic int s_of(input int l);
    return (l == 0) ? S_A : S_B;
  endfunction

  task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d @cyc%0d: got %0h expected %0h", nm, l, cyc, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: scan of 4*S edges after an accepted start, then hold until ready.
  initial begin
    cyc = 0;
    for (int l = 0; l < 2; l++) begin
      m_mode[l] = 0;
      m_e[l]    = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int l = 0; l < 2; l++) begin
        if (!rst_n[l]) begin
          m_mode[l] = 0;
          m_e[l]    = 0;
          q[l].delete();
        end else begin
          case (m_mode[l])
            0: if (start[l]) begin
                 m_mode[l] = 1;
                 m_e[l]    = 0;
                 q[l].push_back('{d: in_vec[l], due: cyc + 4 * s_of(l)});
               end
            1: begin
                 m_e[l]++;
                 if (m_e[l] == 4 * s_of(l)) m_mode[l] = 2;
               end
            default: if (ready[l]) m_mode[l] = 0;
          endcase
        end
      end
    end
  end

  // Mux noise: random except on the clock that precedes a capture edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        if (m_mode[l] == 1 && ((m_e[l] + 1) % s_of(l)) == 0) noise[l] = 1'b0;
        else noise[l] = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: per-cycle select/busy/valid against the model, snapshot against the scoreboard.
  initial begin
    logic       prev_v [2];
    logic [3:0] held   [2];
    exp_t       it;
    for (int l = 0; l < 2; l++) begin
      prev_v[l] = 1'b0;
      held[l]   = 4'b0;
    end
    forever begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        if (rst_n[l]) begin
          chk("sel", l, 32'(sel_o[l]), (m_mode[l] == 1) ? 32'(m_e[l] / s_of(l)) : 32'd0);
          chk("busy", l, 32'(busy_o[l]), 32'(m_mode[l] == 1));
          chk("valid", l, 32'(valid_o[l]), 32'(m_mode[l] == 2));
          if (valid_o[l] && !prev_v[l]) begin
            if (q[l].size() == 0) begin
              chk("snap_unexpected", l, 32'd1, 32'd0);
            end else begin
              it = q[l].pop_front();
              chk("snap_data", l, 32'(data_o[l]), 32'(it.d));
              chk("snap_cycle", l, 32'(cyc), 32'(it.due));
              held[l] = data_o[l];
            end
          end else if (valid_o[l] && prev_v[l]) begin
            chk("held_data", l, 32'(data_o[l]), 32'(held[l]));
          end
          prev_v[l] = valid_o[l];
        end else begin
          prev_v[l] = 1'b0;
        end
      end
    end
  end

  task automatic wait_valid(input int l, input int budget);
    int n = 0;
    while (!valid_o[l] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!valid_o[l]) chk("timeout_valid", l, 32'd0, 32'd1);
  endtask

  task automatic drain(input int l);
    int n = 0;
    start[l] = 1'b0;
    ready[l] = 1'b1;
    while ((busy_o[l] || valid_o[l]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy_o[l] || valid_o[l]) chk("timeout_idle", l, 32'd0, 32'd1);
    ready[l] = 1'b0;
    @(negedge clk);
  endtask

  task automatic directed(input int l, input logic [3:0] vec);
    in_vec[l] = vec;
    ready[l]  = 1'b0;
    start[l]  = 1'b1;
    @(negedge clk);
    start[l]  = 1'b0;
    @(negedge clk);
    start[l]  = 1'b1;             // start while busy must be ignored
    @(negedge clk);
    start[l]  = 1'b0;
    wait_valid(l, 4 * s_of(l) + 4);
    start[l]  = 1'b1;             // start while valid must be ignored
    repeat (5) @(negedge clk);
    start[l]  = 1'b0;
    chk("bp_data", l, 32'(data_o[l]), 32'(vec));
    ready[l]  = 1'b1;
    @(negedge clk);
    ready[l]  = 1'b0;
    chk("post_hs_valid", l, 32'(valid_o[l]), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic mid_reset(input int l);
    int n = 0;
    in_vec[l] = 4'($urandom);
    start[l]  = 1'b1;
    @(negedge clk);
    start[l]  = 1'b0;
    while (sel_o[l] != 2'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_ch2", l, 32'(sel_o[l]), 32'd2);
    #2;
    rst_n[l] = 1'b0;
    #1;
    chk("arst_sel", l, 32'(sel_o[l]), 32'd0);
    chk("arst_busy", l, 32'(busy_o[l]), 32'd0);
    chk("arst_valid", l, 32'(valid_o[l]), 32'd0);
    chk("arst_data", l, 32'(data_o[l]), 32'd0);
    @(negedge clk);
    rst_n[l] = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", l, 32'(busy_o[l]), 32'd0);
  endtask

  task automatic start_ready_done(input int l);
    in_vec[l] = 4'($urandom);
    start[l]  = 1'b1;
    @(negedge clk);
    start[l]  = 1'b0;
    wait_valid(l, 4 * s_of(l) + 4);
    start[l]  = 1'b1;
    ready[l]  = 1'b1;
    @(negedge clk);
    start[l]  = 1'b0;
    ready[l]  = 1'b0;
    repeat (3) @(negedge clk);
    chk("sr_busy", l, 32'(busy_o[l]), 32'd0);
    chk("sr_valid", l, 32'(valid_o[l]), 32'd0);
  endtask

  task automatic random_run(input int l, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if (m_mode[l] == 0) in_vec[l] = 4'($urandom);
      start[l] = ($urandom_range(0, 3) == 0);
      ready[l] = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    drain(l);
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    for (int l = 0; l < 2; l++) begin
      rst_n[l]  = 1'b0;
      start[l]  = 1'b0;
      ready[l]  = 1'b0;
      in_vec[l] = 4'b0;
    end
    #1;
    for (int l = 0; l < 2; l++) begin
      chk("rst_sel", l, 32'(sel_o[l]), 32'd0);
      chk("rst_data", l, 32'(data_o[l]), 32'd0);
    end
    repeat (3) @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      chk("rst_busy", l, 32'(busy_o[l]), 32'd0);
      chk("rst_valid", l, 32'(valid_o[l]), 32'd0);
      rst_n[l] = 1'b1;
    end
    repeat (2) @(negedge clk);

    directed(0, 4'b0101);
    directed(1, 4'b0110);
    for (int l = 0; l < 2; l++) begin
      random_run(l, 400);
      mid_reset(l);
      start_ready_done(l);
      directed(l, 4'($urandom));
    end
    for (int l = 0; l < 2; l++) begin
      drain(l);
      chk("leftover", l, 32'(q[l].size()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
